dom_and_pipe: RTL and testbench
===============================

Name: dom_and_pipe

Overview:
- Parametrised domain-oriented-masking (DOM-indep) AND gadget: WIDTH-bit bitwise AND of two Boolean-masked operands at NSH shares (masking order NSH-1).
- Two-stage registered pipeline with valid/ready handshake and backpressure.
- Used as the nonlinear building block for masked S-box/datapath logic. Successor to the fixed 2-share, 1-bit, free-running DOM AND.

Parameters:
- WIDTH, 8, bits per share (independent bitwise AND lanes).
- NSH, 2, share count; legal 2..4; any other value is a elaboration error.
- NRND, NSH*(NSH-1)/2, derived (localparam); fresh random words consumed per operation.
- CNT_W, 16, width of op_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accept.
- a_sh  in  NSH*WIDTH  shares of a; share s = a_sh[s*WIDTH +: WIDTH].
- b_sh  in  NSH*WIDTH  shares of b, same packing.
- rnd  in  NRND*WIDTH  fresh randomness; pair (i,j), i<j, enumerated lexicographically as k=0,1,… ((0,1)=0, (0,2)=1, …); word k = rnd[k*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- y_sh  out  NSH*WIDTH  shares of y = a & b, same packing.
- op_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (async assert, sync release): out_valid=0, y_sh=0, op_cnt=0, all stage registers and stage-valid bits 0. in_ready is 1 during and after reset.
- Global advance: adv = !out_valid || out_ready. Define in_ready = adv, combinational.
- Input accept: occurs when in_valid && in_ready. Data and valid move through both stages only when adv=1. When adv=0, every register holds its value.
- Stage 1 (registered on accept):
  - Inner terms: inner_i = a_i & b_i.
  - Cross terms for i!=j: c_ij = (a_i & b_j) ^ z_ij, with z_ij = z_ji = rnd word k(min(i,j), max(i,j)).
  - Each c_ij is its own register. No XOR of different cross terms is allowed before this register.
  - s1_valid <= in_valid && in_ready.
- Stage 2 / output: y_i <= inner_i ^ XOR over j!=i of c_ij. out_valid <= s1_valid.
- Latency: exactly 2 cycles from accept to out_valid with no stall. Throughput is 1 op/cycle.
- Correctness: XOR of all y shares equals (XOR a shares) & (XOR b shares), for any rnd.
- rnd is sampled only on accepting cycles. Callers must present fresh rnd for every accept.
- Backpressure: out_valid=1 && out_ready=0 freezes the whole pipe. Holding out_ready low with in_valid high accepts exactly 2 ops total, then in_ready drops.
- Bubbles: a stage with valid=0 still shifts on adv. The data value in a bubble is governed by the Optional Feature.
- op_cnt: increments on out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- Simultaneous output handshake and input accept in the same cycle: both occur, and no bubble is inserted.
- Reset mid-operation: all in-flight ops are discarded and none complete.

Optional Feature:
- Macro: DOM_BUBBLE_CLEAR_EN.
- Defined: when adv=1 and there is no accept, stage-1 registers load 0. When adv=1 and s1_valid=0, y_sh loads 0. Empty slots therefore carry all-zero shares, preventing share recombination through stale-to-new transitions.
- Undefined: bubble slots load the (don't-care) computed values from current inputs. y_sh is meaningful only while out_valid=1.

Test Plan:
1. Basic, NSH=2, WIDTH=8: a_sh={0x99,0x3C}, b_sh={0x5A,0x55}, rnd=0x00, out_ready=1, one accept. Cycle +2: out_valid=1, y0=0x0C, y1=0x09, XOR=0x05. Repeat with rnd=0xFF: y0=0xF3, y1=0xF6.
2. Stream and stall: 4 back-to-back ops, out_ready=0 from cycle 1. in_ready falls after 2 accepts, and y_sh holds op0. Release out_ready: ops appear in order, one per cycle, and op_cnt=4.
3. Randomised NSH=3 and NSH=4: 1000 ops with random shares and rnd. The XOR of the y shares always equals the AND of the unmasked operands, with no lost or duplicated ops.
4. Reset mid-op: assert rst_n=0 with 2 ops in flight. Immediately out_valid=0, y_sh=0, op_cnt=0. After release, a new op completes correctly at +2.
5. Wrap: CNT_W=4, 17 completed handshakes -> op_cnt=1.
6. DOM_BUBBLE_CLEAR_EN defined: op, then 2 idle cycles. y_sh=0 in the cycle after out_valid drops. Undefined: no check on y_sh while out_valid=0.

Source files
------------

// File: rtl/dom_and_pipe.sv
// Two-stage DOM-indep masked AND gadget, NSH shares x WIDTH lanes, valid/ready handshake.
// Optional build macro DOM_BUBBLE_CLEAR_EN: empty pipeline slots carry all-zero shares.
module dom_and_pipe #(
  parameter int WIDTH = 8,
  parameter int NSH   = 2,
  parameter int CNT_W = 16,
  localparam int NRND = NSH * (NSH - 1) / 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSH*WIDTH-1:0]    a_sh,
  input  logic [NSH*WIDTH-1:0]    b_sh,
  input  logic [NRND*WIDTH-1:0]   rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NSH*WIDTH-1:0]    y_sh,
  output logic [CNT_W-1:0]        op_cnt
);

  if (NSH < 2 || NSH > 4) begin : g_nsh_chk
    $error("dom_and_pipe: NSH must be in 2..4");
  end

  // Lexicographic index of share pair (i,j), i<j, into the rnd word list.
  function automatic int pair_idx(input int i, input int j);
    return i * (2 * NSH - i - 1) / 2 + (j - i - 1);
  endfunction

  logic                                 w_adv;
  logic                                 w_acc;
  logic [NSH-1:0][NSH-1:0][WIDTH-1:0]   w_term_p0;
  logic [NSH-1:0][NSH-1:0][WIDTH-1:0]   r_term_p1;
  logic                                 r_vld_p1;
  logic [NSH*WIDTH-1:0]                 w_y_p1;
  logic [NSH*WIDTH-1:0]                 r_y_p2;
  logic                                 r_vld_p2;
  logic [CNT_W-1:0]                     r_cnt;

  assign w_adv     = !r_vld_p2 || out_ready;
  assign w_acc     = in_valid && w_adv;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_p2;
  assign y_sh      = r_y_p2;
  assign op_cnt    = r_cnt;

  // Stage 0 -> 1: diagonal holds the inner term a_i&b_i, off-diagonal the
  // remasked cross term; every term lands in its own register so no two
  // cross products are ever combined before being registered.
  always_comb begin
    w_term_p0 = '0;
    for (int i = 0; i < NSH; i++) begin
      for (int j = 0; j < NSH; j++) begin
        if (i == j)
          w_term_p0[i][j] = a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH];
        else if (i < j)
          w_term_p0[i][j] = (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH])
                            ^ rnd[pair_idx(i, j)*WIDTH +: WIDTH];
        else
          w_term_p0[i][j] = (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH])
                            ^ rnd[pair_idx(j, i)*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_term_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= w_acc;
`ifdef DOM_BUBBLE_CLEAR_EN
      r_term_p1 <= w_acc ? w_term_p0 : '0;
`else
      r_term_p1 <= w_term_p0;
`endif
    end
  end

  // Stage 1 -> 2: output share i compresses row i of the registered terms.
  always_comb begin
    w_y_p1 = '0;
    for (int i = 0; i < NSH; i++) begin
      for (int j = 0; j < NSH; j++) begin
        w_y_p1[i*WIDTH +: WIDTH] = w_y_p1[i*WIDTH +: WIDTH] ^ r_term_p1[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_p2   <= '0;
      r_vld_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p2 <= r_vld_p1;
`ifdef DOM_BUBBLE_CLEAR_EN
      r_y_p2 <= r_vld_p1 ? w_y_p1 : '0;
`else
      r_y_p2 <= w_y_p1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_vld_p2 && out_ready)
      r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_dom_and_pipe.sv
// Directed-vector and randomised bench for dom_and_pipe (NSH=2 with 4-bit counter,
// plus NSH=3 and NSH=4 instances for share-recombination checks).
module tb_dom_and_pipe;

  logic clk;
  logic rst_n;

  // NSH=2 instance
  logic        a_iv, a_ir, a_ov, a_or;
  logic [15:0] a_a, a_b, a_y;
  logic [7:0]  a_r;
  logic [3:0]  a_cnt;

  // NSH=3 (index 0) and NSH=4 (index 1) instances
  logic        ivld [2];
  logic        irdy [2];
  logic        ovld [2];
  logic        ordy [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [47:0] rr [2];
  logic [23:0] y3;
  logic [31:0] y4;
  logic [15:0] c3, c4;

  int n_run;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  r;
    logic [15:0] y;
  } vec_t;
  vec_t vt [5];

  dom_and_pipe #(.WIDTH(8), .NSH(2), .CNT_W(4)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .a_sh(a_a), .b_sh(a_b), .rnd(a_r), .out_valid(a_ov), .out_ready(a_or),
    .y_sh(a_y), .op_cnt(a_cnt)
  );

  dom_and_pipe #(.WIDTH(8), .NSH(3), .CNT_W(16)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .a_sh(ra[0][23:0]), .b_sh(rb[0][23:0]), .rnd(rr[0][23:0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .y_sh(y3), .op_cnt(c3)
  );

  dom_and_pipe #(.WIDTH(8), .NSH(4), .CNT_W(16)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .a_sh(ra[1]), .b_sh(rb[1]), .rnd(rr[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .y_sh(y4), .op_cnt(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xsh(input logic [31:0] v, input int ns);
    logic [7:0] r;
    r = '0;
    for (int s = 0; s < ns; s++) r = r ^ v[s*8 +: 8];
    return r;
  endfunction

  // Stream-test operands (unmasked) and share masks
  logic [7:0] sa [4];
  logic [7:0] sb [4];
  logic [7:0] sm [4];

  task automatic put_op(input int k);
    a_a = {sa[k] ^ sm[k], sm[k]};
    b_sh_set(k);
    a_r = 8'($urandom);
  endtask

  task automatic b_sh_set(input int k);
    a_b = {sb[k] ^ ~sm[k], ~sm[k]};
  endtask

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int accd [2];
  int done [2];

  task automatic rnd_observe();
    logic [31:0] yv;
    logic [7:0]  e;
    for (int u = 0; u < 2; u++) begin
      if (ovld[u] && ordy[u]) begin
        yv = (u == 0) ? {8'h00, y3} : y4;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          chk("rnd unexpected output", 1, 0);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          chk("rnd y recombine", xsh(yv, u + 3), e);
        end
        done[u]++;
      end
      if (ivld[u] && irdy[u]) begin
        e = xsh(ra[u], u + 3) & xsh(rb[u], u + 3);
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        accd[u]++;
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    vt[0] = '{a: 16'h993C, b: 16'h5A55, r: 8'h00, y: 16'h090C};
    vt[1] = '{a: 16'h993C, b: 16'h5A55, r: 8'hFF, y: 16'hF6F3};
    vt[2] = '{a: 16'h00FF, b: 16'h00FF, r: 8'hA5, y: 16'hA55A};
    vt[3] = '{a: 16'hFFFF, b: 16'h0FF0, r: 8'h3C, y: 16'hC3C3};
    vt[4] = '{a: 16'h1234, b: 16'h5678, r: 8'h9A, y: 16'h98BE};
    sa[0] = 8'hC3; sb[0] = 8'h7E; sm[0] = 8'h6D;
    sa[1] = 8'h5A; sb[1] = 8'hFF; sm[1] = 8'h12;
    sa[2] = 8'hF0; sb[2] = 8'h33; sm[2] = 8'hA7;
    sa[3] = 8'h81; sb[3] = 8'h18; sm[3] = 8'h4E;
    a_iv = 0; a_or = 1; a_a = '0; a_b = '0; a_r = '0;
    for (int u = 0; u < 2; u++) begin
      ivld[u] = 0; ordy[u] = 1; ra[u] = '0; rb[u] = '0; rr[u] = '0;
      accd[u] = 0; done[u] = 0;
    end
    rst_n = 0;
    tick();
    tick();
    chk("reset out_valid", a_ov, 0);
    chk("reset y_sh", a_y, 0);
    chk("reset op_cnt", a_cnt, 0);
    chk("reset in_ready", a_ir, 1);
    rst_n = 1;
    tick();

    // Directed single operations
    for (int v = 0; v < 5; v++) begin
      a_iv = 1; a_a = vt[v].a; a_b = vt[v].b; a_r = vt[v].r;
      tick();
      a_iv = 0; a_r = 8'($urandom);
      chk($sformatf("vec%0d valid at +1", v), a_ov, 0);
      tick();
      chk($sformatf("vec%0d valid at +2", v), a_ov, 1);
      chk($sformatf("vec%0d y_sh", v), a_y, vt[v].y);
      tick();
      chk($sformatf("vec%0d valid drop", v), a_ov, 0);
`ifdef DOM_BUBBLE_CLEAR_EN
      chk($sformatf("vec%0d bubble y_sh", v), a_y, 0);
`endif
    end
    chk("op_cnt after vectors", a_cnt, 4'd5);

    // Stream with stall
    a_or = 0;
    a_iv = 1; put_op(0);
    chk("stream in_ready op0", a_ir, 1);
    tick();
    put_op(1);
    chk("stream in_ready op1", a_ir, 1);
    tick();
    put_op(2);
    for (int s = 0; s < 3; s++) begin
      chk("stall in_ready low", a_ir, 0);
      chk("stall out_valid", a_ov, 1);
      chk("stall holds op0", xsh({16'h0, a_y}, 2), sa[0] & sb[0]);
      tick();
    end
    a_or = 1;
    #1;
    chk("release in_ready", a_ir, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain op%0d valid", k), a_ov, 1);
      chk($sformatf("drain op%0d data", k), xsh({16'h0, a_y}, 2), sa[k] & sb[k]);
      @(posedge clk); #1;
      if (k == 0) put_op(3);
      if (k == 1) a_iv = 0;
    end
    chk("drain empty", a_ov, 0);
    chk("op_cnt after stream", a_cnt, 4'd9);

    // Eight more back-to-back ops: 17 handshakes total wraps the 4-bit count to 1
    a_iv = 1;
    for (int k = 0; k < 8; k++) begin
      a_a = 16'($urandom); a_b = 16'($urandom); a_r = 8'($urandom);
      tick();
    end
    a_iv = 0;
    repeat (3) tick();
    chk("op_cnt wrap", a_cnt, 4'd1);

    // Reset with two ops in flight
    a_iv = 1; a_a = vt[0].a; a_b = vt[0].b; a_r = vt[0].r;
    tick();
    a_a = vt[1].a; a_b = vt[1].b; a_r = vt[1].r;
    tick();
    a_iv = 0; a_or = 0;
    chk("pre-reset out_valid", a_ov, 1);
    rst_n = 0;
    #1;
    chk("midop reset out_valid", a_ov, 0);
    chk("midop reset y_sh", a_y, 0);
    chk("midop reset op_cnt", a_cnt, 0);
    chk("midop reset in_ready", a_ir, 1);
    tick();
    rst_n = 1; a_or = 1;
    tick();
    chk("post-reset no ghost 1", a_ov, 0);
    tick();
    chk("post-reset no ghost 2", a_ov, 0);
    a_iv = 1; a_a = vt[4].a; a_b = vt[4].b; a_r = vt[4].r;
    tick();
    a_iv = 0;
    tick();
    chk("post-reset op valid", a_ov, 1);
    chk("post-reset op y_sh", a_y, vt[4].y);

    // Randomised NSH=3 / NSH=4 with random valid and backpressure
    for (int cyc = 0; cyc < 5000 && (accd[0] < 1000 || accd[1] < 1000); cyc++) begin
      for (int u = 0; u < 2; u++) begin
        ivld[u] = (accd[u] < 1000) && ($urandom_range(0, 3) != 0);
        ordy[u] = ($urandom_range(0, 3) != 0);
        ra[u] = $urandom;
        rb[u] = $urandom;
        rr[u][31:0]  = $urandom;
        rr[u][47:32] = 16'($urandom);
      end
      #1;
      rnd_observe();
      @(posedge clk); #1;
    end
    for (int u = 0; u < 2; u++) begin
      ivld[u] = 0;
      ordy[u] = 1;
    end
    for (int d = 0; d < 4; d++) begin
      #1;
      rnd_observe();
      @(posedge clk); #1;
    end
    chk("rnd NSH3 ops accepted", accd[0] >= 1000, 1);
    chk("rnd NSH4 ops accepted", accd[1] >= 1000, 1);
    chk("rnd NSH3 none lost", q0.size(), 0);
    chk("rnd NSH4 none lost", q1.size(), 0);
    chk("rnd NSH3 completed", done[0], accd[0]);
    chk("rnd NSH4 completed", done[1], accd[1]);
    chk("rnd NSH3 op_cnt", c3, 16'(done[0]));
    chk("rnd NSH4 op_cnt", c4, 16'(done[1]));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
